// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an N x N weight-stationary PE array: loads weights, switches them
// in with a row skew, streams M input vectors and drains the array before pulsing done.
module systolic_tile_ctrl #(
    parameter int ARRAY_WIDTH   = 16,
    parameter int DATA_WIDTH_IN = 8,
    parameter int VEC_CNT_WIDTH = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [VEC_CNT_WIDTH-1:0]                      cfg_num_vectors,
    input  logic [ARRAY_WIDTH-1:0]                        cfg_col_en,
    output logic                                          w_rd_en,
    output logic [$clog2(ARRAY_WIDTH)-1:0]                w_rd_addr,
    input  logic [ARRAY_WIDTH*DATA_WIDTH_IN-1:0]          w_rd_data,
    output logic [ARRAY_WIDTH*DATA_WIDTH_IN-1:0]          north_weight,
    output logic [ARRAY_WIDTH*$clog2(ARRAY_WIDTH)-1:0]    north_index,
    output logic [ARRAY_WIDTH-1:0]                        north_accept_w,
    output logic [ARRAY_WIDTH-1:0]                        col_enable,
    output logic                                          a_rd_en,
    output logic [VEC_CNT_WIDTH-1:0]                      a_rd_addr,
    output logic [ARRAY_WIDTH-1:0]                        west_valid,
    output logic [ARRAY_WIDTH-1:0]                        west_switch,
    output logic [ARRAY_WIDTH-1:0]                        top_psum_valid,
    output logic                                          busy,
    output logic                                          done
);

    localparam int N     = ARRAY_WIDTH;
    localparam int IW    = $clog2(N);
    localparam int DW_CW = $clog2(2 * N + 1);
    localparam int CNT_W = (VEC_CNT_WIDTH > DW_CW) ? VEC_CNT_WIDTH : DW_CW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SWITCH,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [VEC_CNT_WIDTH-1:0]   m_q;
    logic [N-1:0]               col_en_q;
    logic                       w_pres_q;
    logic [IW-1:0]              w_idx_q;
    logic [N-1:0]               sw_q;
    logic [N-1:0]               v_q;
    logic                       accept;
    logic                       sw_row0;

    // The tile length only depends on N and the latched M, so every phase ends on a
    // fixed count of the shared counter, which restarts at zero on every transition.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        accept    = 1'b0;
        sw_row0   = 1'b0;
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        a_rd_en   = 1'b0;
        a_rd_addr = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                w_rd_en   = 1'b1;
                w_rd_addr = cnt_q[IW-1:0];
                if (cnt_q == CNT_W'(N - 1)) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(N)) state_d = S_SWITCH;
            end
            S_SWITCH: begin
                busy    = 1'b1;
                sw_row0 = 1'b1;
                state_d = (m_q == '0) ? S_DRAIN : S_COMPUTE;
            end
            S_COMPUTE: begin
                busy      = 1'b1;
                a_rd_en   = 1'b1;
                a_rd_addr = cnt_q[VEC_CNT_WIDTH-1:0];
                if (cnt_q == CNT_W'(m_q) - CNT_W'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (cnt_q == CNT_W'(2 * N)) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            col_en_q <= '0;
            w_pres_q <= 1'b0;
            w_idx_q  <= '0;
            sw_q     <= '0;
            v_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            if (accept) begin
                m_q      <= cfg_num_vectors;
                col_en_q <= cfg_col_en;
            end
            w_pres_q <= w_rd_en;
            w_idx_q  <= w_rd_addr;
            sw_q     <= {sw_q[N-2:0], sw_row0};
            v_q      <= {v_q[N-2:0], a_rd_en};
        end
    end

    // Weight buffer data returns one cycle after the strobe, so the presentation
    // window is the registered strobe and the index is the registered address.
    always_comb begin
        north_index = '0;
        for (int c = 0; c < N; c++) begin
            north_index[c*IW +: IW] = w_pres_q ? w_idx_q : '0;
        end
    end

    assign north_weight   = w_pres_q ? w_rd_data : '0;
    assign north_accept_w = w_pres_q ? col_en_q : '0;
    assign col_enable     = busy ? col_en_q : '0;

    // Bit r of each line is the row-0 event delayed r cycles, matching the input skew.
    assign west_switch    = {sw_q[N-2:0], sw_row0};
    assign west_valid     = v_q;
    assign top_psum_valid = v_q & col_en_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Directed bench for systolic_tile_ctrl (N=4): cycle-by-cycle output checks against the
// tile timeline, plus a small weight-stationary array model fed with identity weights.
module tb_systolic_tile_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int VW = 10;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [VW-1:0]     cfg_num_vectors;
    logic [N-1:0]      cfg_col_en;
    logic              w_rd_en;
    logic [IW-1:0]     w_rd_addr;
    logic [N*DW-1:0]   w_rd_data = '0;
    logic [N*DW-1:0]   north_weight;
    logic [N*IW-1:0]   north_index;
    logic [N-1:0]      north_accept_w;
    logic [N-1:0]      col_enable;
    logic              a_rd_en;
    logic [VW-1:0]     a_rd_addr;
    logic [N-1:0]      west_valid;
    logic [N-1:0]      west_switch;
    logic [N-1:0]      top_psum_valid;
    logic              busy;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_tile_ctrl #(
        .ARRAY_WIDTH  (N),
        .DATA_WIDTH_IN(DW),
        .VEC_CNT_WIDTH(VW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_vectors(cfg_num_vectors),
        .cfg_col_en     (cfg_col_en),
        .w_rd_en        (w_rd_en),
        .w_rd_addr      (w_rd_addr),
        .w_rd_data      (w_rd_data),
        .north_weight   (north_weight),
        .north_index    (north_index),
        .north_accept_w (north_accept_w),
        .col_enable     (col_enable),
        .a_rd_en        (a_rd_en),
        .a_rd_addr      (a_rd_addr),
        .west_valid     (west_valid),
        .west_switch    (west_switch),
        .top_psum_valid (top_psum_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Input vectors: a_mem[j][r] is element r of vector j.
    int a_mem [3][N] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}};

    // Weight buffer holds the identity matrix, 1-cycle read latency.
    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= (N*DW)'(1) << (DW * int'(w_rd_addr));
    end

    // Input buffer, skew buffer and array model.
    int a_q    [N];
    int sk     [N][N];
    int shadow [N][N];
    int wact   [N][N];
    int ar     [N][N];
    int vr     [N][N];
    int swr    [N][N];
    int psr    [N][N];
    int psvr   [N][N];
    int res_val[N][8];
    int res_cnt[N];

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            a_q[r]   <= (a_rd_en && a_rd_addr < 3) ? a_mem[a_rd_addr][r] : 0;
            sk[r][0] <= a_q[r];
            for (int d = 1; d < N; d++) sk[r][d] <= sk[r][d-1];
        end
        for (int c = 0; c < N; c++) begin
            if (north_accept_w[c])
                shadow[north_index[c*IW +: IW]][c] <= int'(north_weight[c*DW +: DW]);
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int a_in, v_in, s_in, p_in, pv_in;
                if (c == 0) begin
                    a_in = (r == 0) ? a_q[0] : sk[r][r-1];
                    v_in = int'(west_valid[r]);
                    s_in = int'(west_switch[r]);
                end else begin
                    a_in = ar[r][c-1];
                    v_in = vr[r][c-1];
                    s_in = swr[r][c-1];
                end
                if (r == 0) begin
                    p_in  = 0;
                    pv_in = int'(top_psum_valid[c]);
                end else begin
                    p_in  = psr[r-1][c];
                    pv_in = psvr[r-1][c];
                end
                ar[r][c]   <= a_in;
                vr[r][c]   <= v_in;
                swr[r][c]  <= s_in;
                psvr[r][c] <= pv_in;
                psr[r][c]  <= p_in + ((v_in != 0) ? a_in * wact[r][c] : 0);
                if (s_in != 0) wact[r][c] <= shadow[r][c];
            end
        end
        for (int c = 0; c < N; c++) begin
            if (psvr[N-1][c] != 0 && res_cnt[c] < 8) begin
                res_val[c][res_cnt[c]] <= psr[N-1][c];
                res_cnt[c]             <= res_cnt[c] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs at cycle k of a tile started at cycle 0; ab forces all-zero.
    task automatic check_outputs(input int k, input int t_done, input int m,
                                 input logic [N-1:0] ce, input bit ab);
        logic          e_busy, e_done, e_wen, e_win, e_aen;
        logic [IW-1:0] e_waddr;
        logic [VW-1:0] e_aaddr;
        logic [N-1:0]  e_sw, e_wv, e_tp;
        logic [N*IW-1:0] e_idx;
        logic [N*DW-1:0] e_nw;
        e_busy  = !ab && k >= 1 && k < t_done;
        e_done  = !ab && k == t_done;
        e_wen   = !ab && k >= 1 && k <= N;
        e_waddr = e_wen ? IW'(k - 1) : '0;
        e_win   = !ab && k >= 2 && k <= N + 1;
        e_idx   = e_win ? {N{IW'(k - 2)}} : '0;
        e_nw    = e_win ? (N*DW)'(1) << (DW * (k - 2)) : '0;
        e_aen   = !ab && k >= 2*N + 3 && k <= 2*N + 2 + m;
        e_aaddr = e_aen ? VW'(k - (2*N + 3)) : '0;
        for (int r = 0; r < N; r++) begin
            e_sw[r] = !ab && k == 2*N + 2 + r;
            e_wv[r] = !ab && k >= 2*N + 4 + r && k <= 2*N + 3 + m + r;
            e_tp[r] = e_wv[r] && ce[r];
        end
        check($sformatf("c%0d busy", k),           64'(busy),           64'(e_busy));
        check($sformatf("c%0d done", k),           64'(done),           64'(e_done));
        check($sformatf("c%0d w_rd_en", k),        64'(w_rd_en),        64'(e_wen));
        check($sformatf("c%0d w_rd_addr", k),      64'(w_rd_addr),      64'(e_waddr));
        check($sformatf("c%0d north_accept_w", k), 64'(north_accept_w), 64'(e_win ? ce : '0));
        check($sformatf("c%0d north_index", k),    64'(north_index),    64'(e_idx));
        check($sformatf("c%0d north_weight", k),   64'(north_weight),   64'(e_nw));
        check($sformatf("c%0d col_enable", k),     64'(col_enable),     64'(e_busy ? ce : '0));
        check($sformatf("c%0d a_rd_en", k),        64'(a_rd_en),        64'(e_aen));
        check($sformatf("c%0d a_rd_addr", k),      64'(a_rd_addr),      64'(e_aaddr));
        check($sformatf("c%0d west_switch", k),    64'(west_switch),    64'(e_sw));
        check($sformatf("c%0d west_valid", k),     64'(west_valid),     64'(e_wv));
        check($sformatf("c%0d top_psum_valid", k), 64'(top_psum_valid), 64'(e_tp));
    endtask

    // mode 0: plain; 1: start re-pulsed at cycle 5; 2: start held in the DONE cycle;
    // 3: rst during cycle 12. k0=1 continues a tile launched from the previous DONE cycle.
    task automatic run_tile(input int m, input logic [N-1:0] ce, input int mode, input int k0);
        int t_done, k_end;
        t_done = 4*N + 4 + m;
        k_end  = (mode == 3) ? t_done + 2 : t_done;
        for (int k = k0; k <= k_end; k++) begin
            @(posedge clk);
            #1;
            start = (k == 0) || (mode == 1 && k == 5) || (mode == 2 && k == t_done);
            rst   = (mode == 3 && k == 12);
            if (k == 0 || (mode == 2 && k == t_done)) begin
                cfg_num_vectors = VW'(m);
                cfg_col_en      = ce;
            end
            if (k == 3) begin
                cfg_num_vectors = VW'(7);
                cfg_col_en      = ~ce;
            end
            @(negedge clk);
            check_outputs(k, t_done, m, ce, mode == 3 && k >= 13);
        end
        if (mode != 2) start = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        cfg_num_vectors = '0;
        cfg_col_en      = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs(0, 1000, 0, '0, 1'b1);
        rst = 1'b0;

        run_tile(3, 4'b1111, 0, 0);
        for (int c = 0; c < N; c++) begin
            check($sformatf("model col%0d psum count", c), 64'(res_cnt[c]), 64'(3));
            for (int j = 0; j < 3; j++)
                check($sformatf("model col%0d psum%0d", c, j),
                      64'(res_val[c][j]), 64'(a_mem[j][c]));
        end

        run_tile(2, 4'b0101, 0, 0);
        run_tile(0, 4'b1111, 0, 0);
        run_tile(2, 4'b0000, 0, 0);
        run_tile(3, 4'b1111, 1, 0);
        run_tile(3, 4'b1011, 2, 0);
        run_tile(3, 4'b1011, 0, 1);
        run_tile(3, 4'b1111, 3, 0);
        run_tile(1, 4'b0110, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
